// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: drives stage-register enables/flushes and the
// PC branch-redirect select. It handles load-use stalls, taken branches
// resolved at EX_MEM, and data-memory waits, with a timeout trap and a
// saturating count of cycles in which the PC was held.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RUN      | normal flow; freeze, branch and load-use rules checked in order
//   MEM_WAIT | data memory busy; pipeline frozen until ready or timeout
//   FLUSH    | branch shadow; IF_ID bubbled for BR_PENALTY advancing cycles
//   ERROR    | memory timeout trap; everything held until reset
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int BR_PENALTY  = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  mem_branch,
  input  logic                  mem_zero,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  pc_sel_branch,
  output logic                  mem_err,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [1:0] S_ERROR    = 2'd3;

  // Wait timer holds the number of further not-ready cycles tolerated; the
  // first not-ready cycle is spent in RUN, so it loads MEM_TIMEOUT-1.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam int FL_W   = $clog2(BR_PENALTY + 1);

  logic [WAIT_W-1:0] wait_rem, wait_nxt;
  logic [FL_W-1:0]   flush_rem, flush_nxt;
  logic [1:0]        state_nxt;
  logic              err_nxt;

  logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [2:0] fl;   // {if_id, id_ex, ex_mem}
  logic       sel;
  logic       run_rules;

  logic freeze, br_taken, load_use;

  assign freeze   = mem_access & ~dmem_ready;
  assign br_taken = mem_branch & mem_zero;
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Mealy outputs and next-state/counter values from state and inputs.
  always_comb begin
    en        = 5'b11111;
    fl        = 3'b000;
    sel       = 1'b0;
    run_rules = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_rem;
    flush_nxt = flush_rem;
    err_nxt   = mem_err;

    case (state)
      S_RUN: begin
        if (freeze) begin
          en        = 5'b00000;
          state_nxt = S_MEM_WAIT;
          wait_nxt  = WAIT_W'(MEM_TIMEOUT - 1);
        end else begin
          run_rules = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        // mem_access stays asserted by the stalled MEM stage; only ready matters.
        if (!dmem_ready) begin
          en = 5'b00000;
          if (wait_rem == WAIT_W'(1)) begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end else begin
            wait_nxt = wait_rem - WAIT_W'(1);
          end
        end else begin
          state_nxt = S_RUN;
          run_rules = 1'b1;
        end
      end
      S_FLUSH: begin
        // ID holds a bubble here, so a load-use check would be meaningless.
        fl[2] = 1'b1;
        if (freeze) begin
          en = 5'b00000;
        end else if (flush_rem <= FL_W'(1)) begin
          state_nxt = S_RUN;
          flush_nxt = '0;
        end else begin
          flush_nxt = flush_rem - FL_W'(1);
        end
      end
      default: begin
        en = 5'b00000;
      end
    endcase

    if (run_rules) begin
      if (br_taken) begin
        sel       = 1'b1;
        fl        = 3'b111;
        state_nxt = S_FLUSH;
        flush_nxt = FL_W'(BR_PENALTY);
      end else if (load_use) begin
        en    = 5'b00111;
        fl[1] = 1'b1;
      end
    end

    if (rst) begin
      en  = 5'b00000;
      fl  = 3'b000;
      sel = 1'b0;
    end
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
  assign {if_id_flush, id_ex_flush, ex_mem_flush}          = fl;
  assign pc_sel_branch                                     = sel;

  // State, timers, sticky trap flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      wait_rem  <= '0;
      flush_rem <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_rem  <= wait_nxt;
      flush_rem <= flush_nxt;
      mem_err   <= err_nxt;
      if (!en[4] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: each driven cycle pushes its expected
// outputs to a queue; a monitor pops and compares them mid-cycle.
module tb_pipeline_hazard_ctrl;

  localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, FLSH = 2'd2, ERR = 2'd3;
  localparam logic [4:0] EN_ALL = 5'b11111, EN_NONE = 5'b00000, EN_LU = 5'b00111;
  localparam logic [2:0] FL_NONE = 3'b000, FL_ALL = 3'b111, FL_ID = 3'b010, FL_IF = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, mem_branch, mem_zero, mem_access, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mread;
    logic       br;
    logic       zero;
    logic       acc;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic [4:0]  en;
    logic [2:0]  fl;
    logic        sel;
    logic [1:0]  st;
    logic        err;
    logic [31:0] stall;
  } exp_t;

  in_t   nx;
  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_stall = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5), .MEM_TIMEOUT(16), .BR_PENALTY(1), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pc_sel_branch(pc_sel_branch), .mem_err(mem_err),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Apply the staged inputs at the falling edge and queue what they should produce.
  task automatic cyc(input string tag, input logic [4:0] en, input logic [2:0] fl,
                     input logic sel, input logic [1:0] st, input logic err);
    exp_t e;
    @(negedge clk);
    rst = nx.rst; id_rs1 = nx.rs1; id_rs2 = nx.rs2; ex_rd = nx.rd;
    ex_mem_read = nx.mread; mem_branch = nx.br; mem_zero = nx.zero;
    mem_access = nx.acc; dmem_ready = nx.rdy;
    e.en = en; e.fl = fl; e.sel = sel; e.st = st; e.err = err;
    e.stall = 32'(exp_stall);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (nx.rst) exp_stall = 0;
    else if (!en[4]) exp_stall++;
  endtask

  task automatic idle();
    nx = '0;
  endtask

  // Monitor: compare the oldest expectation a few ns after inputs settle.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".en"},    32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e.en));
        chk({t, ".flush"}, 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(e.fl));
        chk({t, ".sel"},   32'(pc_sel_branch), 32'(e.sel));
        chk({t, ".state"}, 32'(state), 32'(e.st));
        chk({t, ".err"},   32'(mem_err), 32'(e.err));
        chk({t, ".stall"}, stall_cnt, e.stall);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 0; mem_branch = 0; mem_zero = 0; mem_access = 0; dmem_ready = 0;
    repeat (2) @(posedge clk);

    // Reset and release
    nx.rst = 1'b1;
    cyc("rst0", EN_NONE, FL_NONE, 0, RUN, 0);
    cyc("rst1", EN_NONE, FL_NONE, 0, RUN, 0);
    idle();
    cyc("idle", EN_ALL, FL_NONE, 0, RUN, 0);

    // Load-use on rs1, rs2, and the x0 exemption
    nx.mread = 1; nx.rd = 5; nx.rs1 = 5;
    cyc("lu_rs1", EN_LU, FL_ID, 0, RUN, 0);
    idle();
    cyc("lu_after", EN_ALL, FL_NONE, 0, RUN, 0);
    nx.mread = 1; nx.rd = 7; nx.rs2 = 7; nx.rs1 = 2;
    cyc("lu_rs2", EN_LU, FL_ID, 0, RUN, 0);
    idle();
    nx.mread = 1; nx.rd = 0; nx.rs1 = 0;
    cyc("lu_x0", EN_ALL, FL_NONE, 0, RUN, 0);
    idle();
    nx.mread = 0; nx.rd = 9; nx.rs1 = 9;
    cyc("lu_noload", EN_ALL, FL_NONE, 0, RUN, 0);

    // Taken branch, flush shadow, untaken branch
    idle(); nx.br = 1; nx.zero = 1;
    cyc("br", EN_ALL, FL_ALL, 1, RUN, 0);
    idle(); nx.mread = 1; nx.rd = 4; nx.rs1 = 4;
    cyc("br_fl", EN_ALL, FL_IF, 0, FLSH, 0);
    idle();
    cyc("br_back", EN_ALL, FL_NONE, 0, RUN, 0);
    nx.br = 1; nx.zero = 0;
    cyc("br_nt", EN_ALL, FL_NONE, 0, RUN, 0);

    // Memory wait: three not-ready cycles, then ready
    idle(); nx.acc = 1; nx.rdy = 0;
    cyc("mw1", EN_NONE, FL_NONE, 0, RUN, 0);
    cyc("mw2", EN_NONE, FL_NONE, 0, WAIT, 0);
    cyc("mw3", EN_NONE, FL_NONE, 0, WAIT, 0);
    nx.rdy = 1;
    cyc("mw_rdy", EN_ALL, FL_NONE, 0, WAIT, 0);
    idle();
    cyc("mw_back", EN_ALL, FL_NONE, 0, RUN, 0);

    // Ready cycle of a wait still applies the load-use rule
    nx.acc = 1; nx.rdy = 0;
    cyc("mwl1", EN_NONE, FL_NONE, 0, RUN, 0);
    nx.rdy = 1; nx.mread = 1; nx.rd = 6; nx.rs2 = 6;
    cyc("mwl_rdy", EN_LU, FL_ID, 0, WAIT, 0);
    idle();
    cyc("mwl_back", EN_ALL, FL_NONE, 0, RUN, 0);

    // Timeout: sixteen consecutive not-ready cycles trap
    nx.acc = 1; nx.rdy = 0;
    cyc("to1", EN_NONE, FL_NONE, 0, RUN, 0);
    for (int i = 2; i <= 16; i++) cyc($sformatf("to%0d", i), EN_NONE, FL_NONE, 0, WAIT, 0);
    cyc("to_err", EN_NONE, FL_NONE, 0, ERR, 1);
    nx.rdy = 1;
    cyc("to_hold", EN_NONE, FL_NONE, 0, ERR, 1);
    idle(); nx.br = 1; nx.zero = 1;
    cyc("to_hold2", EN_NONE, FL_NONE, 0, ERR, 1);
    idle(); nx.rst = 1;
    cyc("to_rst", EN_NONE, FL_NONE, 0, ERR, 1);
    idle();
    cyc("to_clr", EN_ALL, FL_NONE, 0, RUN, 0);

    // Freeze beats branch and load-use; branch applied in the ready cycle
    nx.acc = 1; nx.rdy = 0; nx.br = 1; nx.zero = 1; nx.mread = 1; nx.rd = 3; nx.rs1 = 3;
    cyc("sim_frz", EN_NONE, FL_NONE, 0, RUN, 0);
    nx.rdy = 1;
    cyc("sim_rdy", EN_ALL, FL_ALL, 1, WAIT, 0);
    idle();
    cyc("sim_fl", EN_ALL, FL_IF, 0, FLSH, 0);
    cyc("sim_back", EN_ALL, FL_NONE, 0, RUN, 0);

    // Freeze inside the flush shadow pauses the flush count
    nx.br = 1; nx.zero = 1;
    cyc("ff_br", EN_ALL, FL_ALL, 1, RUN, 0);
    idle(); nx.acc = 1; nx.rdy = 0;
    cyc("ff_frz1", EN_NONE, FL_IF, 0, FLSH, 0);
    cyc("ff_frz2", EN_NONE, FL_IF, 0, FLSH, 0);
    nx.rdy = 1;
    cyc("ff_go", EN_ALL, FL_IF, 0, FLSH, 0);
    idle();
    cyc("ff_back", EN_ALL, FL_NONE, 0, RUN, 0);

    // Reset in the middle of a memory wait
    nx.acc = 1; nx.rdy = 0;
    cyc("rw1", EN_NONE, FL_NONE, 0, RUN, 0);
    cyc("rw2", EN_NONE, FL_NONE, 0, WAIT, 0);
    nx.rst = 1;
    cyc("rw_rst", EN_NONE, FL_NONE, 0, WAIT, 0);
    idle();
    cyc("rw_back", EN_ALL, FL_NONE, 0, RUN, 0);

    @(negedge clk);
    #5;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
